// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the board reset sequencer.
package reset_seq_pkg;

   // Sequencer phases: hold all domains, release them one by one, then run.
   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } seq_state_t;

   // Reason the most recent assert/release sequence was started.
   typedef enum logic [1:0] {
      C_POR = 2'd0,
      C_SW  = 2'd1,
      C_WDT = 2'd2
   } rst_cause_t;

   // Counter width able to hold the given terminal count without wrapping.
   function automatic int cnt_width(input int term);
      return $clog2(term) + 1;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between reset software/watchdog side and the sequencer.
//
// Handshake: there is no valid/ready pairing here. sw_rst is a level sampled
// on every clock edge, wdt_kick is a single-cycle pulse sampled on every edge,
// and all status outputs (rst_n_dom, ready, cause, state) are registered and
// valid every cycle.
interface reset_sequencer_if #(
   parameter int NB_DOM = 3
);
   import reset_seq_pkg::*;

   logic               sw_rst;
   logic               wdt_kick;
   logic [NB_DOM-1:0]  rst_n_dom;
   logic               ready;
   rst_cause_t         cause;
   seq_state_t         state;   // debug view of the sequencer FSM

   // Requester side: issues reset requests and kicks, observes status.
   modport master (
      output sw_rst,
      output wdt_kick,
      input  rst_n_dom,
      input  ready,
      input  cause,
      input  state
   );

   // Sequencer side.
   modport slave (
      input  sw_rst,
      input  wdt_kick,
      output rst_n_dom,
      output ready,
      output cause,
      output state
   );

endinterface

// File: rtl/reset_sequencer_wdt_counter.sv
// Watchdog: counts enabled cycles, cleared by a kick or when disabled.
module wdt_counter
   import reset_seq_pkg::*;
#(
   parameter int WDT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic kick,
   output logic timeout
);

   localparam int W = cnt_width(WDT_CYCLES);
   localparam logic [W-1:0] TERM = W'(WDT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // A kick on the terminal cycle wins over the timeout.
   assign timeout = en && !kick && (cnt_q == TERM);

   // Count while enabled; clear on kick, on disable, or at the terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (!en || kick || (cnt_q == TERM)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Watchdog count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: holds all domains in reset, releases them in order
// with a fixed gap, and re-runs the sequence on software request or watchdog
// timeout. Records the cause of the last sequence.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NB_DOM     = 3,
   parameter int HOLD       = 16,
   parameter int GAP        = 8,
   parameter bit WDT_EN     = 1'b1,
   parameter int WDT_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   reset_sequencer_if.slave   bus
);

   localparam int CNT_W = cnt_width(max2(HOLD, GAP));
   localparam int IDX_W = (NB_DOM > 1) ? $clog2(NB_DOM) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_DOM - 1);

   seq_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NB_DOM-1:0]  dom_q, dom_d;
   logic               ready_q, ready_d;
   rst_cause_t         cause_q, cause_d;
   logic               wdt_en;
   logic               wdt_timeout;

   assign wdt_en = (state_q == RUN);

   generate
      if (WDT_EN) begin : g_wdt
         wdt_counter #(
            .WDT_CYCLES (WDT_CYCLES)
         ) u_wdt (
            .clk     (clk),
            .reset   (reset),
            .en      (wdt_en),
            .kick    (bus.wdt_kick),
            .timeout (wdt_timeout)
         );
      end else begin : g_no_wdt
         assign wdt_timeout = 1'b0;
      end
   endgenerate

   // Next state, hold/gap counter, domain index and output values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      cause_d = cause_q;

      if (bus.sw_rst) begin
         // Software request overrides everything, including a watchdog timeout.
         state_d = ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         dom_d   = '0;
         cause_d = C_SW;
      end else begin
         case (state_q)
            ASSERT: begin
               dom_d = '0;
               if (cnt_q == HOLD_LAST) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            RELEASE: begin
               // The first cycle of each gap releases the current domain.
               if (cnt_q == '0) begin
                  for (int i = 0; i < NB_DOM; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        dom_d[i] = 1'b1;
                     end
                  end
               end
               if ((cnt_q == '0) && (idx_q == IDX_LAST)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else if (cnt_q == GAP_LAST) begin
                  cnt_d = '0;
                  idx_d = idx_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            RUN: begin
               if (wdt_timeout) begin
                  state_d = ASSERT;
                  cnt_d   = '0;
                  idx_d   = '0;
                  dom_d   = '0;
                  cause_d = C_WDT;
               end
            end

            default: begin
               state_d = ASSERT;
               cnt_d   = '0;
               idx_d   = '0;
               dom_d   = '0;
            end
         endcase
      end

      // ready trails RUN entry by one edge and drops on the edge that leaves RUN.
      ready_d = (state_q == RUN) && (state_d == RUN);
   end

   // State and output registers; async reset forces a power-on sequence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         ready_q <= 1'b0;
         cause_q <= C_POR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         ready_q <= ready_d;
         cause_q <= cause_d;
      end
   end

   assign bus.rst_n_dom = dom_q;
   assign bus.ready     = ready_q;
   assign bus.cause     = cause_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: schedule table, expected-value queue checked on
// the falling edge, plus hand-written request/watchdog/async-reset sequences.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NB   = 3;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int WDT  = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  reset_sequencer_if #(.NB_DOM(NB)) bus_if();

  reset_sequencer #(
    .NB_DOM     (NB),
    .HOLD       (HOLD),
    .GAP        (GAP),
    .WDT_EN     (1'b1),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- clock / reset / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- release schedule table ----------------
  typedef struct {
    int         off;
    logic [2:0] dom;
    logic       rdy;
  } vec_t;
  vec_t sched[8];

  // ---------------- scoreboard ----------------
  // entry = {edge number[31:0], rst_n_dom[2:0], ready, cause[1:0]}
  logic [37:0] exp_q[$];
  logic [37:0] e;
  int          ec;
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_drops = 0;
  logic        mon_en = 1'b0;

  function void chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  task push_exp(input int c, input logic [2:0] d, input logic r, input logic [1:0] ca);
    exp_q.push_back({c[31:0], d, r, ca});
  endtask

  task push_sched(input int base, input logic [1:0] ca, input int max_off);
    for (int i = 0; i < 8; i++) begin
      if (sched[i].off <= max_off) push_exp(base + sched[i].off, sched[i].dom, sched[i].rdy, ca);
    end
  endtask

  task wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Compare every expectation due at this edge; flag any that slipped past.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][37:6]) <= cyc) begin
      e  = exp_q.pop_front();
      ec = int'(e[37:6]);
      if (ec < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed@%0d: checked at %0d", ec, cyc);
      end else begin
        chk($sformatf("dom@%0d", ec), int'(bus_if.rst_n_dom), int'(e[5:3]));
        chk($sformatf("ready@%0d", ec), int'(bus_if.ready), int'(e[2]));
        chk($sformatf("cause@%0d", ec), int'(bus_if.cause), int'(e[1:0]));
      end
    end
    if (mon_en && !bus_if.ready) ready_drops++;
  end

  // ---------------- stimulus ----------------
  int t;
  int b;

  initial begin
    sched[0] = '{off: 1,  dom: 3'b000, rdy: 1'b0};
    sched[1] = '{off: 16, dom: 3'b000, rdy: 1'b0};
    sched[2] = '{off: 17, dom: 3'b001, rdy: 1'b0};
    sched[3] = '{off: 24, dom: 3'b001, rdy: 1'b0};
    sched[4] = '{off: 25, dom: 3'b011, rdy: 1'b0};
    sched[5] = '{off: 32, dom: 3'b011, rdy: 1'b0};
    sched[6] = '{off: 33, dom: 3'b111, rdy: 1'b0};
    sched[7] = '{off: 34, dom: 3'b111, rdy: 1'b1};

    bus_if.sw_rst   = 1'b0;
    bus_if.wdt_kick = 1'b1;   // keep the watchdog quiet until its own test

    // Reset state while reset is held
    #1;
    chk("por_dom", int'(bus_if.rst_n_dom), 0);
    chk("por_ready", int'(bus_if.ready), 0);
    chk("por_cause", int'(bus_if.cause), int'(C_POR));
    chk("por_state", int'(bus_if.state), int'(ASSERT));

    // Test 1: power-on release schedule
    repeat (3) @(negedge clk);
    reset = 1'b0;
    b = cyc;
    push_sched(b, 2'd0, 99);
    wait_to(b + 40);

    // Test 2: one-cycle software request in RUN
    t = cyc;
    bus_if.sw_rst = 1'b1;
    push_exp(t + 1, 3'b000, 1'b0, 2'd1);
    push_sched(t + 1, 2'd1, 99);
    @(negedge clk);
    bus_if.sw_rst = 1'b0;
    wait_to(t + 41);

    // Test 3: software request held 40 cycles
    t = cyc;
    bus_if.sw_rst = 1'b1;
    for (int k = 1; k <= 40; k++) push_exp(t + k, 3'b000, 1'b0, 2'd1);
    push_sched(t + 40, 2'd1, 99);
    repeat (40) @(negedge clk);
    bus_if.sw_rst = 1'b0;
    wait_to(t + 80);

    // Test 5: request while only domain 0 is released
    t = cyc;
    bus_if.sw_rst = 1'b1;
    b = t + 1;
    push_exp(b, 3'b000, 1'b0, 2'd1);
    push_sched(b, 2'd1, 17);
    push_exp(b + 18, 3'b001, 1'b0, 2'd1);
    push_exp(b + 19, 3'b000, 1'b0, 2'd1);
    @(negedge clk);
    bus_if.sw_rst = 1'b0;
    wait_to(b + 18);
    bus_if.sw_rst = 1'b1;
    push_sched(b + 19, 2'd1, 99);
    @(negedge clk);
    bus_if.sw_rst = 1'b0;
    wait_to(b + 19 + 40);

    // Test 4a: stop kicking in RUN; timeout 100 cycles after the last kick,
    // then again 100 RUN cycles after the re-release.
    t = cyc;
    bus_if.wdt_kick = 1'b0;
    push_exp(t + 99, 3'b111, 1'b1, 2'd1);
    push_exp(t + 100, 3'b000, 1'b0, 2'd2);
    b = t + 100;
    push_sched(b, 2'd2, 99);
    push_exp(b + 132, 3'b111, 1'b1, 2'd2);
    push_exp(b + 133, 3'b000, 1'b0, 2'd2);
    push_sched(b + 133, 2'd2, 99);
    wait_to(b + 133 + 40);

    // Test 4b: kick every 50 cycles for 10000 cycles, no timeout
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus_if.wdt_kick = 1'b1;
      @(negedge clk);
      bus_if.wdt_kick = 1'b0;
      if (i % 40 == 0) chk($sformatf("kick_ready_%0d", i), int'(bus_if.ready), 1);
      repeat (49) @(negedge clk);
    end
    mon_en = 1'b0;
    chk("kick_ready_drops", ready_drops, 0);
    chk("kick_cause", int'(bus_if.cause), int'(C_WDT));

    // Test 6: async reset pulse between edges in RUN
    #2;
    reset = 1'b1;
    #1;
    chk("async_dom", int'(bus_if.rst_n_dom), 0);
    chk("async_ready", int'(bus_if.ready), 0);
    chk("async_cause", int'(bus_if.cause), int'(C_POR));
    #1;
    reset = 1'b0;
    b = cyc;
    push_sched(b, 2'd0, 99);
    wait_to(b + 40);

    // ---------------- report ----------------
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL unchecked@%0d: still queued at end", int'(e[37:6]));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time bound
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time limit at edge %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
